// File: rtl/inst_fetch_pkg.sv
// Shared CPU definitions for the fetch stage: fetch FSM encoding, bus widths,
// the no-op instruction and the reset vector.
package cpu_defs;

  localparam int          CPU_ADDR_W   = 32;
  localparam int          CPU_DATA_W   = 32;
  localparam logic [31:0] CPU_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] RESET_VECTOR = 32'hbfc0_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_FULL  = 2'd1,
    S_DROP  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched {inst, pc, exc} when the decode
// slot is occupied; clear wins over load, load wins over drain.
module fetch_skid_buf #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              drain,
  input  logic              clear,
  input  logic [DATA_W-1:0] in_inst,
  input  logic [ADDR_W-1:0] in_pc,
  input  logic              in_exc,
  output logic              valid,
  output logic [DATA_W-1:0] out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              out_exc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      out_inst <= '0;
      out_pc   <= '0;
      out_exc  <= 1'b0;
    end else if (clear) begin
      valid   <= 1'b0;
      out_exc <= 1'b0;
    end else if (load) begin
      valid    <= 1'b1;
      out_inst <= in_inst;
      out_pc   <= in_pc;
      out_exc  <= in_exc;
    end else if (drain) begin
      valid   <= 1'b0;
      out_exc <= 1'b0;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch sequencer: runs req/ack bus transactions from the PC and
// hands {inst, pc} to decode over valid/ready, discarding responses on flush.
module inst_fetch
  import cpu_defs::*;
#(
  parameter int                ADDR_W   = CPU_ADDR_W,
  parameter int                DATA_W   = CPU_DATA_W,
  parameter logic [DATA_W-1:0] NOP_INST = CPU_NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_advance,
  input  logic              flush,
  output logic              ibus_req,
  output logic [ADDR_W-1:0] ibus_addr,
  input  logic              ibus_ack,
  input  logic [DATA_W-1:0] ibus_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_inst,
  output logic [ADDR_W-1:0] if_pc,
  output logic              if_exc_adel,
  output logic [1:0]        dbg_state
);

  // Handshakes: a decode transfer happens on a cycle with if_valid & if_ready;
  // a bus transfer completes on a cycle with ibus_req & ibus_ack, and once
  // ibus_req rises it holds with a stable ibus_addr until that cycle.

  fetch_state_e      state, state_nxt;
  logic              req_active;
  logic [ADDR_W-1:0] req_addr;
  logic              adel_hold;

  logic              out_fire, slot_free, misaligned;
  logic              load_ack, load_adel, skid_load, skid_drain;

  logic              skid_valid;
  logic [DATA_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_pc;
  logic              skid_exc;

  assign out_fire   = if_valid & if_ready;
  assign slot_free  = !if_valid | out_fire;
  assign misaligned = !req_active && (pc_addr[1:0] != 2'b00);
  assign ibus_addr  = req_active ? req_addr : pc_addr;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      // A request the slave has already seen must run to its ack, so drop it.
      state_nxt = (ibus_req && !ibus_ack) ? S_DROP : S_FETCH;
    end else begin
      unique case (state)
        S_FETCH: if (skid_load)  state_nxt = S_FULL;
        S_FULL:  if (skid_drain) state_nxt = S_FETCH;
        S_DROP:  if (ibus_ack)   state_nxt = S_FETCH;
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  always_comb begin
    ibus_req   = 1'b0;
    pc_advance = 1'b0;
    load_ack   = 1'b0;
    load_adel  = 1'b0;
    skid_load  = 1'b0;
    skid_drain = 1'b0;
    if (rst_n) begin
      unique case (state)
        S_FETCH: begin
          ibus_req = !misaligned;
          if (!misaligned && ibus_ack && !flush) begin
            pc_advance = 1'b1;
            if (slot_free) load_ack  = 1'b1;
            else           skid_load = 1'b1;
          end
          if (misaligned && slot_free && !adel_hold && !flush) load_adel = 1'b1;
        end
        S_FULL: begin
          if (out_fire && skid_valid && !flush) skid_drain = 1'b1;
        end
        S_DROP: begin
          ibus_req = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_active <= 1'b0;
      req_addr   <= '0;
    end else begin
      req_active <= ibus_req & !ibus_ack;
      if (ibus_req && !req_active) req_addr <= pc_addr;
    end
  end

  // The misaligned-PC exception is reported once, then fetch idles until flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         adel_hold <= 1'b0;
    else if (flush)     adel_hold <= 1'b0;
    else if (load_adel) adel_hold <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_pc       <= '0;
      if_exc_adel <= 1'b0;
    end else if (flush) begin
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_exc_adel <= 1'b0;
    end else if (load_ack) begin
      if_valid    <= 1'b1;
      if_inst     <= ibus_rdata;
      if_pc       <= ibus_addr;
      if_exc_adel <= 1'b0;
    end else if (load_adel) begin
      if_valid    <= 1'b1;
      if_inst     <= NOP_INST;
      if_pc       <= pc_addr;
      if_exc_adel <= 1'b1;
    end else if (skid_drain) begin
      if_valid    <= 1'b1;
      if_inst     <= skid_inst;
      if_pc       <= skid_pc;
      if_exc_adel <= skid_exc;
    end else if (out_fire) begin
      if_valid    <= 1'b0;
      if_inst     <= NOP_INST;
      if_exc_adel <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (skid_load),
    .drain    (skid_drain),
    .clear    (flush),
    .in_inst  (ibus_rdata),
    .in_pc    (ibus_addr),
    .in_exc   (1'b0),
    .valid    (skid_valid),
    .out_inst (skid_inst),
    .out_pc   (skid_pc),
    .out_exc  (skid_exc)
  );

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: acts as PC register and bus slave, and predicts the
// decode stream as a queue of acked fetch addresses.
module tb_inst_fetch;
  import cpu_defs::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic        pc_advance;
  logic        flush;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_exc_adel;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  inst_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_addr     (pc_addr),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .ibus_req    (ibus_req),
    .ibus_addr   (ibus_addr),
    .ibus_ack    (ibus_ack),
    .ibus_rdata  (ibus_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_exc_adel (if_exc_adel),
    .dbg_state   (dbg_state)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] pc, held_addr, first_addr;
  int          cnt, lat_min, lat_max, idle, accepts;
  bit          outstanding, stale, adel_wait, junk_en, want_first;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h1357_9bdf ^ {a[15:0], a[31:16]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One bus/decode cycle: drive at negedge, slave answers, then sample and check.
  task automatic cycle(input bit fl, input logic [31:0] tgt, input bit rdy);
    bit          ack, adv;
    logic [31:0] e;
    @(negedge clk);
    pc_addr  = (junk_en && outstanding) ? (pc ^ 32'h0000_1000) : pc;
    flush    = fl;
    if_ready = rdy;
    ibus_ack = 1'b0;
    #1;
    ack = 1'b0;
    if (outstanding) begin
      chk("req_hold", ibus_req, 1);
      chk("addr_hold", ibus_addr, held_addr);
    end else if (pc[1:0] != 2'b00) begin
      chk("no_req_misaligned", ibus_req, 0);
    end
    if (ibus_req) begin
      if (!outstanding) begin
        chk("req_addr", ibus_addr, pc);
        held_addr   = ibus_addr;
        cnt         = $urandom_range(lat_max, lat_min);
        stale       = 1'b0;
        outstanding = 1'b1;
        if (want_first) begin
          first_addr = ibus_addr;
          want_first = 1'b0;
        end
      end
      if (cnt == 0) ack = 1'b1;
      else          cnt--;
    end
    ibus_ack   = ack;
    ibus_rdata = mem_word(held_addr);
    #1;
    adv = ack && !fl && !stale;
    chk("pc_advance", pc_advance, adv);
    if (!if_valid) begin
      chk("idle_inst_nop", if_inst, 32'h0);
      chk("idle_exc_low", if_exc_adel, 0);
    end
    if (if_valid && rdy) begin
      accepts++;
      idle = 0;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out_pc", if_pc, e);
        chk("out_inst", if_inst, mem_word(e));
        chk("out_exc", if_exc_adel, 0);
      end else if (pc[1:0] != 2'b00 && !adel_wait) begin
        chk("adel_exc", if_exc_adel, 1);
        chk("adel_inst", if_inst, 32'h0);
        chk("adel_pc", if_pc, pc);
        adel_wait = 1'b1;
      end else begin
        checks++;
        errors++;
        $display("FAIL unexpected_out actual pc=%h inst=%h required no delivery", if_pc, if_inst);
      end
    end
    if (adv) begin
      exp_q.push_back(held_addr);
      chk("buffer_depth", exp_q.size() <= 2, 1);
    end
    if (ack) outstanding = 1'b0;
    else if (ibus_req && fl) stale = 1'b1;
    if (fl) begin
      pc = tgt;
      exp_q.delete();
      adel_wait  = 1'b0;
      idle       = 0;
      want_first = 1'b1;
    end else if (adv) begin
      pc = pc + 32'd4;
    end
    if (!adel_wait) idle++;
    if (idle > 80) begin
      checks++;
      errors++;
      $display("FAIL timeout actual=no delivery for 80 cycles required=progress");
      idle = 0;
    end
  endtask

  initial begin
    logic [31:0] tgt;
    bit          fl;
    rst_n = 1'b0;
    pc = RESET_VECTOR;
    pc_addr = pc;
    flush = 1'b0;
    if_ready = 1'b0;
    ibus_ack = 1'b0;
    ibus_rdata = '0;
    lat_min = 0; lat_max = 0;
    idle = 0; accepts = 0; cnt = 0;
    outstanding = 0; stale = 0; adel_wait = 0; junk_en = 0; want_first = 0;
    held_addr = '0; first_addr = '0;

    repeat (3) @(negedge clk);
    chk("rst_valid", if_valid, 0);
    chk("rst_inst", if_inst, 32'h0);
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_exc", if_exc_adel, 0);
    chk("rst_req", ibus_req, 0);
    chk("rst_advance", pc_advance, 0);
    chk("rst_state", dbg_state, S_FETCH);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming with zero-wait ack
    cycle(0, 0, 1);
    chk("t1_first_addr", ibus_addr, 32'hbfc0_0000);
    chk("t1_first_valid", if_valid, 0);
    cycle(0, 0, 1);
    chk("t1_valid", if_valid, 1);
    chk("t1_pc0", if_pc, 32'hbfc0_0000);
    cycle(0, 0, 1);
    chk("t1_pc1", if_pc, 32'hbfc0_0004);
    chk("t1_addr2", ibus_addr, 32'hbfc0_0008);
    repeat (5) cycle(0, 0, 1);

    // Three-cycle wait states with PC wobbling during the wait
    lat_min = 3; lat_max = 3; junk_en = 1;
    repeat (16) cycle(0, 0, 1);
    junk_en = 0;

    // Backpressure fills output and skid
    lat_min = 0; lat_max = 0;
    repeat (4) cycle(0, 0, 1);
    repeat (4) cycle(0, 0, 0);
    chk("t3_state_full", dbg_state, S_FULL);
    chk("t3_req_low", ibus_req, 0);
    chk("t3_valid", if_valid, 1);
    repeat (6) cycle(0, 0, 1);

    // Flush coincident with ack
    cycle(1, 32'h8000_0200, 1);
    cycle(0, 0, 0);
    chk("t5a_valid", if_valid, 0);
    chk("t5a_addr", ibus_addr, 32'h8000_0200);
    repeat (4) cycle(0, 0, 1);

    // Flush while in S_FULL
    repeat (4) cycle(0, 0, 0);
    chk("t5b_state_full", dbg_state, S_FULL);
    cycle(1, 32'h8000_0300, 0);
    cycle(0, 0, 0);
    chk("t5b_valid", if_valid, 0);
    chk("t5b_addr", ibus_addr, 32'h8000_0300);
    chk("t5b_state", dbg_state, S_FETCH);
    repeat (4) cycle(0, 0, 1);

    // Flush one cycle after a request starts; response arrives later
    lat_min = 3; lat_max = 3;
    for (int i = 0; i < 10 && !(outstanding && cnt == 2); i++) cycle(0, 0, 1);
    cycle(1, 32'h8000_0180, 1);
    cycle(0, 0, 1);
    chk("t4_valid", if_valid, 0);
    chk("t4_state_drop", dbg_state, S_DROP);
    repeat (10) cycle(0, 0, 1);
    chk("t4_redirect", first_addr, 32'h8000_0180);

    // Misaligned PC
    lat_min = 0; lat_max = 0;
    repeat (4) cycle(0, 0, 1);
    cycle(1, 32'hbfc0_0002, 0);
    cycle(0, 0, 0);
    cycle(0, 0, 0);
    chk("t6_valid", if_valid, 1);
    chk("t6_exc", if_exc_adel, 1);
    chk("t6_inst", if_inst, 32'h0);
    chk("t6_pc", if_pc, 32'hbfc0_0002);
    chk("t6_req", ibus_req, 0);
    cycle(0, 0, 1);
    repeat (4) cycle(0, 0, 1);
    chk("t6_idle_valid", if_valid, 0);
    chk("t6_idle_req", ibus_req, 0);
    cycle(1, 32'hbfc0_0100, 1);
    repeat (6) cycle(0, 0, 1);
    chk("t6_resumed", if_valid, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        lat_max = $urandom_range(3, 0);
        lat_min = $urandom_range(lat_max, 0);
      end
      fl  = ($urandom_range(99, 0) < 4);
      tgt = $urandom;
      tgt[1:0] = ($urandom_range(9, 0) == 0) ? 2'($urandom_range(3, 1)) : 2'b00;
      cycle(fl, tgt, $urandom_range(3, 0) != 0);
    end
    chk("accepts_seen", accepts > 500, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
